// File: rtl/mem_sram_responder_pkg.sv
// Shared memory-protocol definitions: message field layout, op encodings,
// length decode and the byte-lane helpers used by the SRAM responder.
package mem_sram_responder_pkg;

    // Op encodings carried in the top bit of every request and response
    typedef enum logic {
        MEM_OP_READ  = 1'b0,
        MEM_OP_WRITE = 1'b1
    } mem_op_e;

    // Request layout, MSB to LSB: {op, opaque, addr[31:0], len[1:0], data[31:0]}
    localparam int MEM_DATA_LSB     = 0;
    localparam int MEM_REQ_LEN_LSB  = 32;
    localparam int MEM_REQ_ADDR_LSB = 34;
    localparam int MEM_REQ_OPAQ_LSB = 66;

    // Response layout, MSB to LSB: {op, opaque, len[1:0], data[31:0]}
    localparam int MEM_RESP_LEN_LSB  = 32;
    localparam int MEM_RESP_OPAQ_LSB = 34;

    function automatic int mem_req_width(input int opaq_bits);
        return 67 + opaq_bits;
    endfunction

    function automatic int mem_resp_width(input int opaq_bits);
        return 35 + opaq_bits;
    endfunction

    // len 0 means a full word, otherwise it is the byte count
    function automatic logic [2:0] mem_len_decode(input logic [1:0] len);
        logic [2:0] n;
        if (len == 2'd0) begin
            n = 3'd4;
        end else begin
            n = {1'b0, len};
        end
        return n;
    endfunction

    // Lanes offset..offset+n-1, naturally clipped at lane 3
    function automatic logic [3:0] mem_byte_mask(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] mask;
        logic [2:0] hi;
        logic [2:0] lane;
        hi   = {1'b0, off} + mem_len_decode(len);
        mask = 4'b0000;
        for (int j = 0; j < 4; j++) begin
            lane    = 3'(j);
            mask[j] = (lane >= {1'b0, off}) && (lane < hi);
        end
        return mask;
    endfunction

    // Request data byte i moves to lane offset+i
    function automatic logic [31:0] mem_write_lanes(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    // Word shifted down by the offset, lanes at or beyond the byte count zeroed
    function automatic logic [31:0] mem_read_extract(input logic [31:0] word, input logic [1:0] off,
                                                     input logic [1:0] len);
        logic [31:0] res;
        logic [2:0]  n;
        n   = mem_len_decode(len);
        res = word >> {off, 3'b000};
        for (int j = 0; j < 4; j++) begin
            if (3'(j) >= n) begin
                res[8*j +: 8] = 8'h00;
            end else begin
                res[8*j +: 8] = res[8*j +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_resp_fifo.sv
// Response FIFO: register array with read/write pointers and an occupancy
// count. Push into a full FIFO is honoured only when a pop frees a slot in
// the same cycle; pop of an empty FIFO is ignored.
module mem_resp_fifo #(
    parameter int  p_depth   = 4,
    parameter type payload_t = logic [31:0],
    localparam int CW        = $clog2(p_depth + 1),
    localparam int PW        = (p_depth > 1) ? $clog2(p_depth) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  payload_t      push_data,
    input  logic          pop,
    output payload_t      pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    payload_t      store_r [p_depth];
    logic          push_eff_s;
    logic          pop_eff_s;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        logic [PW-1:0] nxt;
        if (ptr == PW'(p_depth - 1)) begin
            nxt = '0;
        end else begin
            nxt = ptr + PW'(1);
        end
        return nxt;
    endfunction

    // Qualify push/pop against the current occupancy
    always_comb begin
        empty      = (count_r == CW'(0));
        full       = (count_r == CW'(p_depth));
        pop_eff_s  = pop && !empty;
        push_eff_s = push && (!full || pop_eff_s);
    end

    // Storage, pointers and occupancy; reset clears contents so the head reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < p_depth; i++) begin
                store_r[i] <= '0;
            end
        end else begin
            if (push_eff_s) begin
                store_r[wr_ptr_r] <= push_data;
                wr_ptr_r          <= next_ptr(wr_ptr_r);
            end
            if (pop_eff_s) begin
                rd_ptr_r <= next_ptr(rd_ptr_r);
            end
            case ({push_eff_s, pop_eff_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign pop_data = store_r[rd_ptr_r];
    assign count    = count_r;

endmodule

// File: rtl/mem_sram_responder.sv
// Single-port SRAM responder for the processor memory protocol. Requests are
// accepted under credit flow control, read/write the word array on the accept
// edge, travel a fixed-latency pipeline and return in order via a FIFO.
module mem_sram_responder
    import mem_sram_responder_pkg::*;
#(
    parameter int p_opaq_bits  = 8,
    parameter int p_num_words  = 1024,
    parameter int p_latency    = 2,
    parameter int p_resp_depth = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   mem_req_val,
    output logic                                   mem_req_rdy,
    input  logic [mem_req_width(p_opaq_bits)-1:0]  mem_req_msg,
    output logic                                   mem_resp_val,
    input  logic                                   mem_resp_rdy,
    output logic [mem_resp_width(p_opaq_bits)-1:0] mem_resp_msg,
    input  logic                                   init_en,
    input  logic [31:0]                            init_addr,
    input  logic [31:0]                            init_data
);

    localparam int REQ_W  = mem_req_width(p_opaq_bits);
    localparam int RESP_W = mem_resp_width(p_opaq_bits);
    localparam int AW     = $clog2(p_num_words);
    localparam int FCW    = $clog2(p_resp_depth + 1);
    localparam int CNT_W  = $clog2(p_resp_depth + p_latency + 1);
    localparam int NC     = (p_latency > 2) ? (p_latency - 2) : 0;

    typedef logic [RESP_W-1:0] resp_t;

    // Request field decode
    logic                   req_op_s;
    logic [p_opaq_bits-1:0] req_opaq_s;
    logic [31:0]            req_addr_s;
    logic [1:0]             req_len_s;
    logic [31:0]            req_data_s;
    logic [AW-1:0]          req_idx_s;
    logic [1:0]             req_off_s;
    logic                   accept_s;

    assign req_op_s   = mem_req_msg[REQ_W-1];
    assign req_opaq_s = mem_req_msg[MEM_REQ_OPAQ_LSB +: p_opaq_bits];
    assign req_addr_s = mem_req_msg[MEM_REQ_ADDR_LSB +: 32];
    assign req_len_s  = mem_req_msg[MEM_REQ_LEN_LSB +: 2];
    assign req_data_s = mem_req_msg[MEM_DATA_LSB +: 32];
    assign req_idx_s  = req_addr_s[AW+1:2];
    assign req_off_s  = req_addr_s[1:0];

    // Credit accounting
    logic [FCW-1:0]   fifo_count_s;
    logic [CNT_W-1:0] inflight_s;
    logic [CNT_W-1:0] credits_used_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             push_s;
    resp_t            push_pl_s;
    logic             pop_s;

    assign credits_used_s = CNT_W'(fifo_count_s) + inflight_s;
    assign mem_req_rdy    = !rst && !init_en && (credits_used_s < CNT_W'(p_resp_depth));
    assign accept_s       = mem_req_val && mem_req_rdy;

    // Address bits above the array and below word alignment do not select storage
    logic unused_bits_s;
    assign unused_bits_s = ^{req_addr_s[31:AW+2], init_addr[31:AW+2], init_addr[1:0], fifo_full_s};

    // Word array with a single byte-enabled write port
    logic [31:0]   mem_array_r [p_num_words];
    logic          wr_en_s;
    logic [AW-1:0] wr_idx_s;
    logic [3:0]    wr_be_s;
    logic [31:0]   wr_data_s;

    // Write-port mux: backdoor init wins, it also blocks acceptance that cycle
    always_comb begin
        wr_en_s   = 1'b0;
        wr_idx_s  = req_idx_s;
        wr_be_s   = 4'b0000;
        wr_data_s = 32'h0000_0000;
        if (init_en) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = init_addr[AW+1:2];
            wr_be_s   = 4'b1111;
            wr_data_s = init_data;
        end else if (accept_s && (req_op_s == MEM_OP_WRITE)) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = req_idx_s;
            wr_be_s   = mem_byte_mask(req_off_s, req_len_s);
            wr_data_s = mem_write_lanes(req_data_s, req_off_s);
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Array write commit; contents intentionally survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int j = 0; j < 4; j++) begin
                if (wr_be_s[j]) begin
                    mem_array_r[wr_idx_s][8*j +: 8] <= wr_data_s[8*j +: 8];
                end
            end
        end
    end

    generate
        if (p_latency == 1) begin : g_lat1
            logic [31:0] rd_word_s;

            // Latency 1 writes the FIFO head on the accept edge, so the read is combinational
            always_comb begin
                rd_word_s  = mem_array_r[req_idx_s];
                push_s     = accept_s;
                inflight_s = '0;
                if (req_op_s == MEM_OP_WRITE) begin
                    push_pl_s = {req_op_s, req_opaq_s, req_len_s, 32'h0000_0000};
                end else begin
                    push_pl_s = {req_op_s, req_opaq_s, req_len_s,
                                 mem_read_extract(rd_word_s, req_off_s, req_len_s)};
                end
            end
        end else begin : g_latn
            logic                   s0_val_r;
            logic                   s0_op_r;
            logic [p_opaq_bits-1:0] s0_opaq_r;
            logic [1:0]             s0_len_r;
            logic [1:0]             s0_off_r;
            logic [31:0]            s0_word_r;
            resp_t                  s0_pl_s;

            // Stage 0: synchronous array read and request capture on the accept edge
            always_ff @(posedge clk) begin
                if (rst) begin
                    s0_val_r  <= 1'b0;
                    s0_op_r   <= 1'b0;
                    s0_opaq_r <= '0;
                    s0_len_r  <= 2'd0;
                    s0_off_r  <= 2'd0;
                    s0_word_r <= 32'h0000_0000;
                end else begin
                    s0_val_r <= accept_s;
                    if (accept_s) begin
                        s0_op_r   <= req_op_s;
                        s0_opaq_r <= req_opaq_s;
                        s0_len_r  <= req_len_s;
                        s0_off_r  <= req_off_s;
                        s0_word_r <= mem_array_r[req_idx_s];
                    end
                end
            end

            // Format the response payload from the stage-0 read word
            always_comb begin
                if (s0_op_r == MEM_OP_WRITE) begin
                    s0_pl_s = {s0_op_r, s0_opaq_r, s0_len_r, 32'h0000_0000};
                end else begin
                    s0_pl_s = {s0_op_r, s0_opaq_r, s0_len_r,
                               mem_read_extract(s0_word_r, s0_off_r, s0_len_r)};
                end
            end

            if (NC == 0) begin : g_direct
                // Stage 0 feeds the FIFO directly
                always_comb begin
                    push_s     = s0_val_r;
                    push_pl_s  = s0_pl_s;
                    inflight_s = CNT_W'(s0_val_r);
                end
            end else begin : g_carry
                logic  carry_val_r [NC];
                resp_t carry_pl_r  [NC];

                // Carry stages delay the formatted payload to reach the target latency
                always_ff @(posedge clk) begin
                    if (rst) begin
                        for (int i = 0; i < NC; i++) begin
                            carry_val_r[i] <= 1'b0;
                            carry_pl_r[i]  <= '0;
                        end
                    end else begin
                        carry_val_r[0] <= s0_val_r;
                        carry_pl_r[0]  <= s0_pl_s;
                        for (int i = 1; i < NC; i++) begin
                            carry_val_r[i] <= carry_val_r[i-1];
                            carry_pl_r[i]  <= carry_pl_r[i-1];
                        end
                    end
                end

                // Last carry stage pushes; every stage valid holds one credit
                always_comb begin
                    push_s     = carry_val_r[NC-1];
                    push_pl_s  = carry_pl_r[NC-1];
                    inflight_s = CNT_W'(s0_val_r);
                    for (int i = 0; i < NC; i++) begin
                        inflight_s = inflight_s + CNT_W'(carry_val_r[i]);
                    end
                end
            end
        end
    endgenerate

    assign pop_s        = mem_resp_val && mem_resp_rdy;
    assign mem_resp_val = !fifo_empty_s;

    mem_resp_fifo #(
        .p_depth   (p_resp_depth),
        .payload_t (resp_t)
    ) u_resp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_pl_s),
        .pop       (pop_s),
        .pop_data  (mem_resp_msg),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_mem_sram_responder.sv
// Directed self-checking bench for mem_sram_responder.
module tb_mem_sram_responder;
    import mem_sram_responder_pkg::*;

    localparam int OPQ    = 8;
    localparam int NW     = 1024;
    localparam int LAT    = 2;
    localparam int DEPTH  = 4;
    localparam int REQ_W  = mem_req_width(OPQ);
    localparam int RESP_W = mem_resp_width(OPQ);

    logic              clk = 1'b0;
    logic              rst;
    logic              req_val;
    logic              req_rdy;
    logic [REQ_W-1:0]  req_msg;
    logic              resp_val;
    logic              resp_rdy;
    logic [RESP_W-1:0] resp_msg;
    logic              init_en;
    logic [31:0]       init_addr;
    logic [31:0]       init_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit acc_seen;
    int last_acc_cyc;
    bit lat_check_en;
    int first_cyc;
    int n_acc;
    logic [RESP_W-1:0] cur_exp;
    logic [RESP_W-1:0] exp_q[$];
    int                acc_cyc_q[$];

    always #5 clk = ~clk;

    mem_sram_responder #(
        .p_opaq_bits  (OPQ),
        .p_num_words  (NW),
        .p_latency    (LAT),
        .p_resp_depth (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_req_val  (req_val),
        .mem_req_rdy  (req_rdy),
        .mem_req_msg  (req_msg),
        .mem_resp_val (resp_val),
        .mem_resp_rdy (resp_rdy),
        .mem_resp_msg (resp_msg),
        .init_en      (init_en),
        .init_addr    (init_addr),
        .init_data    (init_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes mid-cycle, then advance past the edge
    task automatic step();
        int lat;
        @(negedge clk);
        acc_seen = req_val && req_rdy;
        if (acc_seen) begin
            exp_q.push_back(cur_exp);
            acc_cyc_q.push_back(cyc);
            last_acc_cyc = cyc;
        end
        if (resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_resp", 64'(resp_msg), 64'd0);
            end else begin
                check_eq("resp_msg", 64'(resp_msg), 64'(exp_q[0]));
                lat = cyc - acc_cyc_q[0];
                if (lat_check_en) check_eq("resp_latency", 64'(lat), 64'(LAT));
                void'(exp_q.pop_front());
                void'(acc_cyc_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive_req(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                             input logic [1:0] len, input logic [31:0] data, input logic [31:0] exp_data);
        req_msg = {op, opq, addr, len, data};
        cur_exp = {op, opq, len, exp_data};
        req_val = 1'b1;
    endtask

    task automatic send_req(input logic op, input logic [7:0] opq, input logic [31:0] addr,
                            input logic [1:0] len, input logic [31:0] data, input logic [31:0] exp_data);
        drive_req(op, opq, addr, len, data, exp_data);
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc_seen) break;
        end
        if (!acc_seen) check_eq("accept_timeout", 64'(acc_seen), 64'd1);
        req_val = 1'b0;
    endtask

    task automatic init_word(input logic [31:0] addr, input logic [31:0] data);
        init_en   = 1'b1;
        init_addr = addr;
        init_data = data;
        step();
        init_en   = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) step();
        check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_val = 1'b0; req_msg = '0; resp_rdy = 1'b0;
        init_en = 1'b0; init_addr = 32'h0; init_data = 32'h0;
        lat_check_en = 1'b0; cur_exp = '0; last_acc_cyc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_req_rdy", 64'(req_rdy), 64'd0);
        check_eq("rst_resp_val", 64'(resp_val), 64'd0);
        check_eq("rst_resp_msg", 64'(resp_msg), 64'd0);
        rst = 1'b0;
        #1;
        check_eq("credits_full", 64'(req_rdy), 64'd1);

        // Backdoor load, then basic read with latency check
        init_en = 1'b1; init_addr = 32'h100; init_data = 32'hDEAD_BEEF;
        #1;
        check_eq("init_blocks_rdy", 64'(req_rdy), 64'd0);
        step();
        init_en = 1'b0;
        resp_rdy = 1'b1; lat_check_en = 1'b1;
        send_req(MEM_OP_READ, 8'h5A, 32'h100, 2'd0, 32'h0, 32'hDEAD_BEEF);
        drain();

        // Sub-word write, read-after-write and sub-word read
        send_req(MEM_OP_WRITE, 8'h01, 32'h101, 2'd1, 32'h0000_00AB, 32'h0);
        send_req(MEM_OP_READ,  8'h02, 32'h100, 2'd0, 32'h0, 32'hDEAD_ABEF);
        send_req(MEM_OP_READ,  8'h03, 32'h102, 2'd2, 32'h0, 32'h0000_DEAD);
        drain();

        // 16 back-to-back reads
        for (int i = 0; i < 16; i++) init_word(32'h200 + 32'(4 * i), 32'hA500_0000 | 32'(i));
        first_cyc = 0;
        for (int i = 0; i < 16; i++) begin
            send_req(MEM_OP_READ, 8'(i), 32'h200 + 32'(4 * i), 2'd0, 32'h0, 32'hA500_0000 | 32'(i));
            if (i == 0) first_cyc = last_acc_cyc;
        end
        check_eq("stream_back_to_back", 64'(last_acc_cyc - first_cyc), 64'd15);
        drain();

        // Backpressure: credits run out at the FIFO depth
        lat_check_en = 1'b0; resp_rdy = 1'b0; n_acc = 0;
        drive_req(MEM_OP_READ, 8'h20, 32'h200, 2'd0, 32'h0, 32'hA500_0000);
        repeat (10) begin
            step();
            if (acc_seen) begin
                n_acc++;
                drive_req(MEM_OP_READ, 8'h20 + 8'(n_acc), 32'h200 + 32'(4 * n_acc), 2'd0, 32'h0,
                          32'hA500_0000 | 32'(n_acc));
            end
        end
        check_eq("bp_accepted", 64'(n_acc), 64'(DEPTH));
        check_eq("bp_rdy_low", 64'(req_rdy), 64'd0);
        check_eq("bp_resp_val", 64'(resp_val), 64'd1);
        check_eq("bp_head_held", 64'(resp_msg), 64'(exp_q[0]));
        req_val = 1'b0; resp_rdy = 1'b1;
        step();
        check_eq("bp_rdy_after_pop", 64'(req_rdy), 64'd1);
        drain();

        // Reset with three transactions in flight
        resp_rdy = 1'b0;
        send_req(MEM_OP_WRITE, 8'h30, 32'h300, 2'd0, 32'h1122_3344, 32'h0);
        send_req(MEM_OP_READ,  8'h31, 32'h200, 2'd0, 32'h0, 32'hA500_0000);
        send_req(MEM_OP_READ,  8'h32, 32'h204, 2'd0, 32'h0, 32'hA500_0001);
        rst = 1'b1;
        step();
        check_eq("rst_flush_val", 64'(resp_val), 64'd0);
        step();
        rst = 1'b0;
        exp_q.delete(); acc_cyc_q.delete();
        resp_rdy = 1'b1;
        repeat (6) step();
        check_eq("rst_no_resp", 64'(resp_val), 64'd0);
        lat_check_en = 1'b1;
        send_req(MEM_OP_READ, 8'h33, 32'h300, 2'd0, 32'h0, 32'h1122_3344);
        drain();

        // Address aliasing modulo the array size
        send_req(MEM_OP_READ, 8'h34, 32'h100 + 32'(4 * NW), 2'd0, 32'h0, 32'hDEAD_ABEF);
        drain();

        // Init concurrent with a request: request waits one cycle
        init_en = 1'b1; init_addr = 32'h400; init_data = 32'h55AA_55AA;
        drive_req(MEM_OP_READ, 8'h35, 32'h100, 2'd0, 32'h0, 32'hDEAD_ABEF);
        step();
        check_eq("init_req_no_accept", 64'(acc_seen), 64'd0);
        init_en = 1'b0;
        step();
        check_eq("accept_after_init", 64'(acc_seen), 64'd1);
        req_val = 1'b0;
        drain();
        send_req(MEM_OP_READ, 8'h36, 32'h400, 2'd0, 32'h0, 32'h55AA_55AA);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
